// File: rtl/serial_deframer_pkg.sv
// serial_deframer_pkg: shared state encoding and default parameters for the serial deframer.
// Rev 1.0
`default_nettype none

package serial_deframer_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2
  } state_t;

  localparam int         DEF_WIDTH       = 8;
  localparam logic [7:0] DEF_SYNC_WORD   = 8'hA5;
  localparam int         DEF_FRAME_WORDS = 4;

endpackage

`default_nettype wire

// File: rtl/deframer_sipo.sv
// deframer_sipo: WIDTH-bit MSB-first shift register with shift enable and synchronous clear.
// Rev 1.0
`default_nettype none

module deframer_sipo
  import serial_deframer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             din_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else if (clr_i) begin
      sr_q <= '0;
    end else if (shift_i) begin
      sr_q <= {sr_q[WIDTH-2:0], din_i};
    end
  end

  assign q_o = sr_q;

endmodule

`default_nettype wire

// File: rtl/serial_deframer.sv
// serial_deframer: hunts a serial stream for SYNC_WORD, then emits FRAME_WORDS words MSB-first.
// Rev 1.0. Optional even-parity bit per word with macro SERIAL_DEFRAMER_PARITY_EN.
`default_nettype none

module serial_deframer
  import serial_deframer_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(DEF_SYNC_WORD),
  parameter int               FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             data_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             locked,
  output logic             frame_done,
  output logic             parity_err
);

  localparam int BCW = $clog2(WIDTH);
  localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);

  state_t           state_q, state_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             word_valid_q, word_valid_d;
  logic             locked_q;
  logic             frame_done_q, frame_done_d;

  logic [WIDTH-1:0] win_q, asm_q, win_next, emit_word;
  logic             win_shift, win_clr, asm_shift, asm_clr, emit;

  deframer_sipo #(.WIDTH(WIDTH)) u_window (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (win_clr),
    .shift_i (win_shift),
    .din_i   (data_in),
    .q_o     (win_q)
  );

  deframer_sipo #(.WIDTH(WIDTH)) u_assemble (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (asm_clr),
    .shift_i (asm_shift),
    .din_i   (data_in),
    .q_o     (asm_q)
  );

  assign win_next = WIDTH'({win_q, data_in});

`ifdef SERIAL_DEFRAMER_PARITY_EN
  logic parity_err_q, parity_err_d;
`else
  logic [WIDTH-1:0] asm_next;
  assign asm_next = WIDTH'({asm_q, data_in});
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    frame_done_d = 1'b0;
    win_shift    = 1'b0;
    win_clr      = 1'b0;
    asm_shift    = 1'b0;
    asm_clr      = 1'b0;
    emit         = 1'b0;
    emit_word    = asm_q;
`ifdef SERIAL_DEFRAMER_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (bit_valid) begin
      unique case (state_q)
        HUNT: begin
          win_shift = 1'b1;
          if (win_next == SYNC_WORD) begin
            state_d    = COLLECT;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            asm_clr    = 1'b1;
          end
        end
        COLLECT: begin
          asm_shift = 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
            state_d   = PARITY;
`else
            emit      = 1'b1;
            emit_word = asm_next;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
`ifdef SERIAL_DEFRAMER_PARITY_EN
        PARITY: begin
          // Even parity: the word plus its parity bit must carry an even number of ones.
          if ((^asm_q) ^ data_in) begin
            parity_err_d = 1'b1;
            state_d      = HUNT;
            win_clr      = 1'b1;
          end else begin
            state_d = COLLECT;
            emit    = 1'b1;
          end
        end
`endif
        default: state_d = HUNT;
      endcase
    end
    if (emit) begin
      word_d       = emit_word;
      word_valid_d = 1'b1;
      if (word_cnt_q == WORD_LAST) begin
        // Clearing the window keeps payload bits from re-triggering a lock.
        frame_done_d = 1'b1;
        state_d      = HUNT;
        win_clr      = 1'b1;
        word_cnt_d   = '0;
      end else begin
        word_cnt_d = word_cnt_q + WCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HUNT;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      locked_q     <= (state_d != HUNT);
      frame_done_q <= frame_done_d;
    end
  end

`ifdef SERIAL_DEFRAMER_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign locked     = locked_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_deframer.sv
// tb_serial_deframer: directed and random bit streams checked against a bit-queue frame model.
// Rev 1.0
`default_nettype none

module tb_serial_deframer;

`ifdef SERIAL_DEFRAMER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int         W    = 8;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         FW   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_valid = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] word_out;
  logic       word_valid, locked, frame_done, parity_err;

  serial_deframer #(.WIDTH(W), .SYNC_WORD(SYNC), .FRAME_WORDS(FW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .data_in    (data_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .locked     (locked),
    .frame_done (frame_done),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit         hist[$];
  bit         pay[$];
  bit         m_locked;
  int         m_words;
  logic [7:0] e_word;
  bit         e_wv, e_fd, e_pe;
  logic [7:0] obs_q[$];
  int         idle_mode = 0;
  int         nbits = 0;

  function automatic logic [7:0] q2byte(input bit q[$]);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[6:0], q[i]};
    return r;
  endfunction

  task automatic clear_window();
    hist.delete();
    repeat (W) hist.push_back(1'b0);
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_words  = 0;
    pay.delete();
    clear_window();
    e_word = '0;
    e_wv = 1'b0; e_fd = 1'b0; e_pe = 1'b0;
  endtask

  task automatic model_edge(input bit b, input bit v);
    int ones;
    e_wv = 1'b0; e_fd = 1'b0; e_pe = 1'b0;
    if (!v) return;
    if (!m_locked) begin
      hist.push_back(b);
      void'(hist.pop_front());
      if (q2byte(hist) == SYNC) begin
        m_locked = 1'b1;
        m_words  = 0;
        pay.delete();
      end
    end else begin
      pay.push_back(b);
      if (pay.size() == W + PAR) begin
        ones = 0;
        foreach (pay[i]) ones += int'(pay[i]);
        if (PAR == 0 || ones % 2 == 0) begin
          e_word = q2byte(pay);
          e_wv   = 1'b1;
          m_words++;
          if (m_words == FW) begin
            e_fd = 1'b1;
            m_locked = 1'b0;
            clear_window();
          end
        end else begin
          e_pe = 1'b1;
          m_locked = 1'b0;
          clear_window();
        end
        pay.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("word_out",   {24'd0, word_out}, {24'd0, e_word});
    chk("word_valid", {31'd0, word_valid}, {31'd0, e_wv});
    chk("locked",     {31'd0, locked}, {31'd0, m_locked});
    chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
    chk("parity_err", {31'd0, parity_err}, {31'd0, e_pe});
  endtask

  task automatic step(input bit b, input bit v);
    data_in   = b;
    bit_valid = v;
    @(posedge clk);
    model_edge(b, v);
    #1;
    check_all();
    if (word_valid === 1'b1) obs_q.push_back(word_out);
  endtask

  task automatic send_bit(input bit b);
    step(b, 1'b1);
    nbits++;
    if (idle_mode == 1 && nbits % 3 == 0) begin
      step(1'($urandom), 1'b0);
      step(1'($urandom), 1'b0);
    end else if (idle_mode == 2 && $urandom_range(3) == 0) begin
      step(1'($urandom), 1'b0);
    end
  endtask

  task automatic send_byte(input logic [7:0] w, input bit with_par, input bit bad_par);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    if (with_par && PAR == 1) send_bit((^w) ^ bad_par);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    send_byte(SYNC, 1'b0, 1'b0);
    send_byte(a, 1'b1, 1'b0);
    send_byte(b, 1'b1, 1'b0);
    send_byte(c, 1'b1, 1'b0);
    send_byte(d, 1'b1, 1'b0);
  endtask

  task automatic expect_words(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
    logic [7:0] exp_w[4];
    exp_w = '{a, b, c, d};
    chk({tag, "_count"}, obs_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk({tag, "_word"}, (i < obs_q.size()) ? {24'd0, obs_q[i]} : 32'hxxxxxxxx, {24'd0, exp_w[i]});
    obs_q.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (n) begin
      data_in   = 1'($urandom);
      bit_valid = 1'($urandom);
      @(posedge clk);
      #1;
      check_all();
    end
    rst = 1'b1;
    obs_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    #2;
    // Reset held with random inputs
    do_reset(3);

    // Basic frame
    send_frame(8'h3C, 8'hC3, 8'hFF, 8'h00);
    expect_words("basic", 8'h3C, 8'hC3, 8'hFF, 8'h00);

    // Same frame with two idle cycles after every third bit
    idle_mode = 1;
    nbits = 0;
    send_frame(8'h3C, 8'hC3, 8'hFF, 8'h00);
    expect_words("idle", 8'h3C, 8'hC3, 8'hFF, 8'h00);
    idle_mode = 0;

    // Near-miss sync word A4 must not lock
    send_bit(1'b1);
    send_bit(1'b1);
    send_byte(8'hA4, 1'b0, 1'b0);
    chk("nearmiss_unlocked", {31'd0, locked}, 32'd0);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44);
    expect_words("nearmiss", 8'h11, 8'h22, 8'h33, 8'h44);

    // Reset mid-frame discards the partial word
    send_byte(SYNC, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    do_reset(1);
    send_byte(8'h3C, 1'b1, 1'b0);
    chk("post_reset_no_words", obs_q.size(), 32'd0);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04);
    expect_words("midreset", 8'h01, 8'h02, 8'h03, 8'h04);

`ifdef SERIAL_DEFRAMER_PARITY_EN
    send_byte(SYNC, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b1);
    chk("badpar_no_words", obs_q.size(), 32'd0);
    send_frame(8'h81, 8'h7E, 8'h55, 8'h0F);
    expect_words("parity", 8'h81, 8'h7E, 8'h55, 8'h0F);
`endif

    // Random noise, frames and idles against the model
    idle_mode = 2;
    repeat (10) begin
      repeat ($urandom_range(12)) send_bit(1'($urandom));
      send_byte(SYNC, 1'b0, 1'b0);
      for (int k = 0; k < FW; k++)
        send_byte(8'($urandom), 1'b1, (PAR == 1) && ($urandom_range(7) == 0));
    end
    repeat (3) step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
